pc_unit_ras: RTL

Parametrised program-counter unit, successor to the single-width PC register. Selects next fetch address from sequential increment, an external redirect (branch/jump) or an internal return-address stack (RAS). Adds hold/stall, call/return tracking, target alignment checking and a configurable reset vector. Sits at the head of the fetch stage; PC drives instruction memory and PCPlusInst feeds the link-register writeback path.

---
 rtl/pc_pkg.sv | 14 +
 rtl/ras_stack.sv | 67 ++++++
 rtl/pc_unit_ras.sv | 78 +++++++
 3 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and next-PC select encoding for the fetch PC unit
package pc_pkg;

    localparam int          PC_XLEN_DEF         = 32;
    localparam int          PC_INST_BYTES_DEF   = 4;
    localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ      = 2'd0,
        SEL_REDIRECT = 2'd1,
        SEL_RAS      = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with push, pop and replace-top
module ras_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            en,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] entries [DEPTH];
    logic [PW-1:0]   ptr, ptr_nxt, waddr;
    logic [CW-1:0]   count, count_nxt;
    logic            we;

    always_comb begin
        ptr_nxt   = ptr;
        count_nxt = count;
        waddr     = ptr;
        we        = 1'b0;
        if (en) begin
            if (push && pop && (count != '0)) begin
                we = 1'b1;
            end else if (push) begin
                // Pointer wraps, so a push onto a full stack overwrites the oldest entry.
                ptr_nxt = ptr + 1'b1;
                waddr   = ptr_nxt;
                we      = 1'b1;
                if (count != CW'(DEPTH)) count_nxt = count + 1'b1;
            end else if (pop && (count != '0)) begin
                ptr_nxt   = ptr - 1'b1;
                count_nxt = count - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ptr   <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            ptr   <= ptr_nxt;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    // Storage is not reset; count alone decides which entries are meaningful.
    always_ff @(posedge CLK) begin
        if (we && !Reset) entries[waddr] <= push_data;
    end

    assign top = entries[ptr];

endmodule

// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - fetch program counter with redirect, return-address stack and fault pulses
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int              XLEN         = PC_XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEF),
    parameter int              INST_BYTES   = PC_INST_BYTES_DEF,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            EN,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectTarget,
    input  logic            Call,
    input  logic            Return,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlusInst,
    output logic            RasEmpty,
    output logic            RasFull,
    output logic            MisalignFault,
    output logic            RasUnderflow
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

    pc_sel_e         sel;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] ras_top;
    logic            misalign_nxt;
    logic            underflow_nxt;

    assign PCPlusInst = PC + XLEN'(INST_BYTES);

    always_comb begin
        sel = SEL_SEQ;
        if (Redirect)                 sel = SEL_REDIRECT;
        else if (Return && !RasEmpty) sel = SEL_RAS;

        case (sel)
            SEL_REDIRECT: pc_nxt = RedirectTarget & ~ALIGN_MASK;
            SEL_RAS:      pc_nxt = ras_top;
            default:      pc_nxt = PCPlusInst;
        endcase
    end

    // A simultaneous Call turns an empty-stack Return into a plain push, so no underflow.
    assign misalign_nxt  = EN && Redirect && |(RedirectTarget & ALIGN_MASK);
    assign underflow_nxt = EN && Return && !Call && RasEmpty;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            PC            <= RESET_VECTOR;
            MisalignFault <= 1'b0;
            RasUnderflow  <= 1'b0;
        end else begin
            if (EN) PC <= pc_nxt;
            MisalignFault <= misalign_nxt;
            RasUnderflow  <= underflow_nxt;
        end
    end

    ras_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .Reset     (Reset),
        .en        (EN),
        .push      (Call),
        .pop       (Return),
        .push_data (PCPlusInst),
        .top       (ras_top),
        .empty     (RasEmpty),
        .full      (RasFull)
    );

endmodule
